// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding uart_core: buffers CPU-written bytes and issues them
// one at a time with a guard window after each strobe.
module uart_tx_fifo #(
  parameter int DATA_W       = 8,
  parameter int DEPTH_LOG2   = 4,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rst_soft_i,
  input  logic                  wr_en_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  overflow_o,
  input  logic                  ovf_clr_i,
  input  logic                  tx_en_i,
  input  logic                  tx_ready_i,
  output logic [DATA_W-1:0]     tx_data_o,
  output logic                  tx_write_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    GUARD_INIT = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0]    GUARD_ONE  = CNT_W'(1);
  localparam logic [DEPTH_LOG2:0] FULL_LVL   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LVL_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT} state_e;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  full_q, empty_q, ovf_q, tx_write_q;
  logic [DATA_W-1:0]     tx_data_q;
  logic [CNT_W-1:0]      guard_q;
  state_e                state_q;

  logic srst, push, issue;

  assign srst  = rst_i | rst_soft_i;
  // full_q is the pre-edge flag, so a push racing a pop while full is refused.
  assign push  = wr_en_i & ~full_q;
  assign issue = (state_q == S_IDLE) & tx_en_i & ~empty_q & tx_ready_i;

  always_comb begin
    level_d = level_q;
    case ({push, issue})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push && !srst) begin
      mem_q[wptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      tx_write_q <= 1'b0;
      tx_data_q  <= '0;
      guard_q    <= '0;
      state_q    <= S_IDLE;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (issue) rptr_q <= rptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == FULL_LVL);
      empty_q <= (level_d == '0);

      if (wr_en_i && full_q) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr_i) begin
        ovf_q <= 1'b0;
      end

      tx_write_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // The byte is latched and popped on the same edge the strobe rises.
          if (issue) begin
            tx_data_q  <= mem_q[rptr_q];
            tx_write_q <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          guard_q <= GUARD_INIT;
          state_q <= S_GUARD;
        end
        S_GUARD: begin
          // Leave as the count reaches zero so back-to-back strobes sit
          // GUARD_CYCLES+2 cycles apart when the core is always ready.
          if (guard_q <= GUARD_ONE) begin
            state_q <= S_WAIT;
          end else begin
            guard_q <= guard_q - 1'b1;
          end
        end
        S_WAIT: begin
          if (tx_ready_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign level_o    = level_q;
  assign overflow_o = ovf_q;
  assign tx_data_o  = tx_data_q;
  assign tx_write_o = tx_write_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: latency, fill/overflow, wrap, full+pop race,
// soft reset mid-guard and ready stall with strobe spacing.
module tb_uart_tx_fifo;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       rst_soft_i = 1'b0;
  logic       wr_en_i = 1'b0;
  logic [7:0] wr_data_i = 8'h00;
  logic       full_o, empty_o, overflow_o, tx_write_o;
  logic [4:0] level_o;
  logic       ovf_clr_i = 1'b0;
  logic       tx_en_i = 1'b0;
  logic       tx_ready_i;
  logic [7:0] tx_data_o;

  logic       ready_man = 1'b1;
  logic       core_mode = 1'b0;
  int         busy = 0;

  int         checks = 0;
  int         errors = 0;
  int         ncyc = 0;
  int         max_lvl = 0;
  logic [7:0] strb_q [$];
  int         strb_cyc [$];

  always #5 clk_i = ~clk_i;

  uart_tx_fifo #(.DATA_W(8), .DEPTH_LOG2(4), .GUARD_CYCLES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rst_soft_i(rst_soft_i),
    .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .full_o(full_o), .empty_o(empty_o), .level_o(level_o),
    .overflow_o(overflow_o), .ovf_clr_i(ovf_clr_i),
    .tx_en_i(tx_en_i), .tx_ready_i(tx_ready_i),
    .tx_data_o(tx_data_o), .tx_write_o(tx_write_o)
  );

  // Core model: optionally drops ready for 10 cycles after each strobe.
  assign tx_ready_i = core_mode ? (busy == 0) : ready_man;

  always @(posedge clk_i) begin
    if (tx_write_o) busy <= 10;
    else if (busy != 0) busy <= busy - 1;
  end

  always @(negedge clk_i) begin
    ncyc++;
    if (tx_write_o) begin
      strb_q.push_back(tx_data_o);
      strb_cyc.push_back(ncyc);
    end
    if (int'(level_o) > max_lvl) max_lvl = int'(level_o);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    wr_en_i = 1'b1;
    wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k;
    k = 0;
    while (strb_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("strobe_count", strb_q.size(), n);
  endtask

  task automatic clear_strobes();
    strb_q.delete();
    strb_cyc.delete();
  endtask

  initial begin
    tick();
    tick();
    rst_i = 1'b0;
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_write", tx_write_o, 0);
    chk("rst_data", tx_data_o, 0);

    // Single byte latency.
    tx_en_i = 1'b1;
    ready_man = 1'b1;
    clear_strobes();
    push_byte(8'h41);
    chk("lat_c1_empty", empty_o, 0);
    chk("lat_c1_level", level_o, 1);
    chk("lat_c1_write", tx_write_o, 0);
    tick();
    chk("lat_c2_write", tx_write_o, 1);
    chk("lat_c2_data", tx_data_o, 8'h41);
    chk("lat_c2_level", level_o, 0);
    chk("lat_c2_empty", empty_o, 1);
    tick();
    chk("lat_c3_write", tx_write_o, 0);
    for (int i = 0; i < 10; i++) tick();
    chk("lat_one_strobe", strb_q.size(), 1);

    // Fill with drain disabled, then overflow.
    tx_en_i = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk("fill_full", full_o, 1);
    chk("fill_level", level_o, 16);
    push_byte(8'hFF);
    chk("fill_ovf", overflow_o, 1);
    chk("fill_level_kept", level_o, 16);
    clear_strobes();
    core_mode = 1'b1;
    tx_en_i = 1'b1;
    wait_strobes(16, 400);
    for (int i = 0; i < 16 && i < strb_q.size(); i++) chk($sformatf("fill_data%0d", i), strb_q[i], i);
    for (int i = 0; i < 20; i++) tick();
    core_mode = 1'b0;
    chk("fill_drained_empty", empty_o, 1);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;
    chk("ovf_cleared", overflow_o, 0);

    // Pointer wrap with interleaved push and drain.
    clear_strobes();
    max_lvl = 0;
    for (int i = 0; i < 40; i++) begin
      push_byte(8'(i));
      tick();
      tick();
    end
    wait_strobes(40, 100);
    for (int i = 0; i < 40 && i < strb_q.size(); i++) chk($sformatf("wrap_data%0d", i), strb_q[i], i);
    chk("wrap_max_le16", max_lvl <= 16, 1);
    chk("wrap_no_ovf", overflow_o, 0);
    for (int i = 0; i < 6; i++) tick();

    // Push while full racing an ISSUE pop, with ovf_clr in the same cycle.
    tx_en_i = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'h50 + 8'(i));
    chk("race_full", full_o, 1);
    clear_strobes();
    tx_en_i = 1'b1;
    wr_en_i = 1'b1;
    wr_data_i = 8'hEE;
    ovf_clr_i = 1'b1;
    tick();
    wr_en_i = 1'b0;
    ovf_clr_i = 1'b0;
    chk("race_level", level_o, 15);
    chk("race_ovf", overflow_o, 1);
    chk("race_full_after", full_o, 0);
    chk("race_write", tx_write_o, 1);
    chk("race_data", tx_data_o, 8'h50);
    wait_strobes(16, 200);
    for (int i = 0; i < 16 && i < strb_q.size(); i++) chk($sformatf("race_data%0d", i), strb_q[i], 8'h50 + i);
    for (int i = 0; i < 10; i++) tick();
    chk("race_no_extra", strb_q.size(), 16);
    ovf_clr_i = 1'b1;
    tick();
    ovf_clr_i = 1'b0;

    // Soft reset while in GUARD with 5 bytes queued.
    tx_en_i = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'h60 + 8'(i));
    tx_en_i = 1'b1;
    begin
      int k;
      k = 0;
      while (!tx_write_o && k < 20) begin
        tick();
        k++;
      end
    end
    chk("srst_issue_seen", tx_write_o, 1);
    chk("srst_issue_level", level_o, 5);
    tick();
    rst_soft_i = 1'b1;
    tick();
    rst_soft_i = 1'b0;
    chk("srst_level", level_o, 0);
    chk("srst_empty", empty_o, 1);
    chk("srst_write", tx_write_o, 0);
    chk("srst_data", tx_data_o, 0);
    clear_strobes();
    for (int i = 0; i < 30; i++) tick();
    chk("srst_no_strobes", strb_q.size(), 0);

    // Ready stall, then resume with spacing check.
    ready_man = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(8'h70 + 8'(i));
    clear_strobes();
    for (int i = 0; i < 50; i++) tick();
    chk("stall_no_strobe", strb_q.size(), 0);
    chk("stall_level", level_o, 3);
    ready_man = 1'b1;
    wait_strobes(3, 60);
    for (int i = 0; i < 3 && i < strb_q.size(); i++) chk($sformatf("stall_data%0d", i), strb_q[i], 8'h70 + i);
    if (strb_cyc.size() >= 3) begin
      chk("spacing_0_1", strb_cyc[1] - strb_cyc[0], 4);
      chk("spacing_1_2", strb_cyc[2] - strb_cyc[1], 4);
    end
    chk("stall_end_empty", empty_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit buffer directly upstream of uart_core.
- Absorbs bytes written by the CPU-side register logic into a circular FIFO.
- Drains the FIFO into uart_core one byte at a time. Each byte is presented on tx_data_o and tx_write_o pulses only when the core reports tx_ready.
- Lets software burst up to 2**DEPTH_LOG2 bytes without polling TXREADY per byte.

Parameters:
- DATA_W, 8: width of one UART character.
- DEPTH_LOG2, 4: log2 of FIFO depth (depth = 16).
- GUARD_CYCLES, 2: cycles after a tx_write_o pulse during which tx_ready_i is ignored (covers core ready-drop latency); must be >= 1.

Ports:
- clk_i  in  1  system clock, all logic rising-edge.
- rst_i  in  1  synchronous, active-high reset.
- rst_soft_i  in  1  synchronous soft reset; same effect as rst_i.
- wr_en_i  in  1  push request, one byte per cycle.
- wr_data_i  in  DATA_W  byte to push.
- full_o  out  1  FIFO holds 2**DEPTH_LOG2 entries.
- empty_o  out  1  FIFO holds 0 entries.
- level_o  out  DEPTH_LOG2+1  current occupancy.
- overflow_o  out  1  sticky: push attempted while full.
- ovf_clr_i  in  1  clears overflow_o.
- tx_en_i  in  1  drain enable (TXEN).
- tx_ready_i  in  1  uart_core tx_ready_o.
- tx_data_o  out  DATA_W  byte to uart_core tx_data_i.
- tx_write_o  out  1  one-cycle strobe to uart_core data_write_en_i.

Behaviour:
- Reset (rst_i or rst_soft_i at a clock edge):
  - Read and write pointers and level go to 0.
  - empty_o=1, full_o=0, level_o=0, overflow_o=0, tx_write_o=0, tx_data_o=0.
  - FSM goes to IDLE.
  - Reset during any FSM state aborts that state; an in-flight byte is dropped.
- Storage: 2**DEPTH_LOG2 x DATA_W array.
  - Pointers are DEPTH_LOG2 bits and wrap naturally from depth-1 to 0.
  - level_o is a separate counter, DEPTH_LOG2+1 bits.
- Push: when wr_en_i=1 and full_o=0, write wr_data_i at wptr, wptr+1.
  - wr_en_i=1 while full: data discarded, pointers unchanged, overflow_o<=1 next cycle.
- Overflow clear: ovf_clr_i=1 clears overflow_o. If a discarded push and ovf_clr_i occur in the same cycle, set wins (overflow_o=1).
- Pop: occurs only on the FSM ISSUE transition (below): rptr+1.
- Simultaneous push and pop: level unchanged.
  - Push while full in the same cycle as a pop is still rejected, because full_o is evaluated before the pop.
- Flags: full_o, empty_o and level_o are registered and reflect state after the edge.
  - A byte pushed into an empty FIFO is visible (empty_o=0) one cycle later.
- FSM:
  - IDLE: if tx_en_i=1, empty_o=0 and tx_ready_i=1 -> ISSUE.
  - ISSUE (1 cycle):
    - tx_data_o<=mem[rptr] one cycle earlier, i.e. on the IDLE->ISSUE edge, so data is stable while the strobe is high.
    - tx_write_o=1, pop.
    - -> GUARD with guard counter=GUARD_CYCLES-1.
  - GUARD: tx_write_o=0, tx_ready_i ignored; counter decrements; at 0 -> WAIT.
  - WAIT: when tx_ready_i=1 -> IDLE.
- Bytes are strobed at most once every GUARD_CYCLES+2 cycles.
- tx_data_o holds the last issued byte until the next issue.
- tx_en_i deasserted mid-operation: a byte already in ISSUE/GUARD/WAIT completes the sequence; no new issue occurs from IDLE while tx_en_i=0. FIFO contents are retained.
- Pushes continue to be accepted regardless of tx_en_i.
- Latency, empty FIFO to strobe (tx_en_i=1, tx_ready_i=1): push at cycle 0, empty_o=0 at 1, IDLE->ISSUE edge at 1, tx_write_o=1 during cycle 2.

Test Plan:
- Push 0x41 with tx_en_i=1, tx_ready_i=1 -> tx_write_o high exactly one cycle, 2 cycles after push, with tx_data_o=0x41; level_o returns to 0 and empty_o=1.
- tx_en_i=0, push 16 bytes 0x00..0x0F -> full_o=1, level_o=16; 17th push of 0xFF sets overflow_o; then assert tx_en_i with a core model that drops ready for 10 cycles after each write -> strobes carry 0x00..0x0F in order, 0xFF never appears.
- Pointer wrap: push/drain 40 bytes 0x00..0x27 interleaved -> output order exactly 0x00..0x27, level_o never exceeds 16.
- With level_o=16, push and ISSUE pop in the same cycle -> push rejected, overflow_o=1, level_o=15; same cycle as ovf_clr_i -> overflow_o stays 1.
- Pulse rst_soft_i while in GUARD with 5 bytes queued -> next cycle level_o=0, empty_o=1, tx_write_o=0, FSM IDLE; no further strobes.
- Hold tx_ready_i=0 for 50 cycles with 3 bytes queued -> no strobe; ready high -> strobes resume; tx_ready_i staying 1 through GUARD -> spacing exactly GUARD_CYCLES+2 cycles between strobes.
